// File: rtl/gru_pkg.sv
// Shared constants, FSM encoding and saturation helper for the GRU hidden-state update.
package gru_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 16;
  localparam int unsigned FRAC_BITS_DEF  = 8;
  localparam int unsigned ONE            = 1 << FRAC_BITS_DEF;
  localparam int unsigned SAT_W          = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  // Clip a wide signed value into the signed range of a w-bit word.
  function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] x,
                                                       input int unsigned w);
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    logic signed [SAT_W-1:0] r;
    max_v = $signed((SAT_W'(1) << (w - 1)) - SAT_W'(1));
    min_v = ~max_v;
    r     = x;
    if (x > max_v) r = max_v;
    else if (x < min_v) r = min_v;
    return r;
  endfunction

endpackage

// File: rtl/gru_blend_pipe.sv
// Two-stage blend datapath: n + ((clamp(z) * (h - n)) >>> FRAC_BITS), saturated.
module gru_blend_pipe
  import gru_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned FRAC_BITS  = FRAC_BITS_DEF,
  parameter int unsigned IDX_W      = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [IDX_W-1:0]             in_idx,
  input  logic signed [DATA_WIDTH-1:0] z_in,
  input  logic signed [DATA_WIDTH-1:0] n_in,
  input  logic signed [DATA_WIDTH-1:0] h_prev,
  output logic                         res_valid_c,
  output logic [IDX_W-1:0]             res_idx_c,
  output logic signed [DATA_WIDTH-1:0] res_c
);

  localparam int unsigned DIFF_W = DATA_WIDTH + 1;
  localparam int unsigned PROD_W = 2 * DATA_WIDTH + 2;
  localparam logic signed [DATA_WIDTH-1:0] ONE_V = DATA_WIDTH'(64'd1 << FRAC_BITS);

  logic signed [DATA_WIDTH-1:0] zc_c;
  logic signed [DIFF_W-1:0]     diff_c;
  logic                         s1_valid;
  logic [IDX_W-1:0]             s1_idx;
  logic signed [DATA_WIDTH-1:0] s1_zc;
  logic signed [DATA_WIDTH-1:0] s1_n;
  logic signed [DIFF_W-1:0]     s1_diff;
  logic signed [PROD_W-1:0]     prod_c;
  logic signed [PROD_W-1:0]     shift_c;
  logic signed [PROD_W-1:0]     sum_c;

  // Stage 1 inputs: clamp gate to [0, ONE] and form the widened difference.
  always_comb begin
    zc_c = z_in;
    if (z_in[DATA_WIDTH-1]) zc_c = '0;
    else if (z_in > ONE_V) zc_c = ONE_V;
    diff_c = DIFF_W'(h_prev) - DIFF_W'(n_in);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_zc    <= '0;
      s1_n     <= '0;
      s1_diff  <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_idx   <= in_idx;
      s1_zc    <= zc_c;
      s1_n     <= n_in;
      s1_diff  <= diff_c;
    end
  end

  // Stage 2: multiply, floor-shift, add, saturate; the caller registers the result.
  always_comb begin
    prod_c      = PROD_W'(s1_zc) * PROD_W'(s1_diff);
    shift_c     = prod_c >>> FRAC_BITS;
    sum_c       = shift_c + PROD_W'(s1_n);
    res_c       = DATA_WIDTH'(saturate(SAT_W'(sum_c), DATA_WIDTH));
    res_valid_c = s1_valid;
    res_idx_c   = s1_idx;
  end

endmodule

// File: rtl/gru_hidden_state_update.sv
// Streams z/n elements through the blend pipe into a shadow buffer, then commits h_state.
module gru_hidden_state_update
  import gru_pkg::*;
#(
  parameter int unsigned H          = 256,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned FRAC_BITS  = FRAC_BITS_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             h_clear,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic signed [DATA_WIDTH-1:0]     z_in,
  input  logic signed [DATA_WIDTH-1:0]     n_in,
  output logic [H-1:0][DATA_WIDTH-1:0]     h_state,
  output logic                             busy,
  output logic                             done
);

  localparam int unsigned CNT_W = (H > 1) ? $clog2(H) : 1;

  state_t                        state;
  state_t                        state_nx;
  logic [CNT_W-1:0]              cnt;
  logic [H-1:0][DATA_WIDTH-1:0]  h_next;
  logic                          accept_c;
  logic                          last_c;
  logic                          res_valid_c;
  logic [CNT_W-1:0]              res_idx_c;
  logic signed [DATA_WIDTH-1:0]  res_c;

  assign accept_c = in_valid && in_ready;
  assign last_c   = accept_c && (cnt == CNT_W'(H - 1));

  gru_blend_pipe #(
    .DATA_WIDTH(DATA_WIDTH),
    .FRAC_BITS (FRAC_BITS),
    .IDX_W     (CNT_W)
  ) u_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (accept_c),
    .in_idx     (cnt),
    .z_in       (z_in),
    .n_in       (n_in),
    .h_prev     ($signed(h_state[cnt])),
    .res_valid_c(res_valid_c),
    .res_idx_c  (res_idx_c),
    .res_c      (res_c)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last_c) state_nx = DRAIN;
      DRAIN:   state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      in_ready <= (state_nx == RUN);
      busy     <= (state_nx != IDLE);
      done     <= (state == COMMIT);
      if (state == IDLE && start) cnt <= '0;
      else if (accept_c) cnt <= cnt + CNT_W'(1);
    end
  end

  // Shadow buffer collects results; h_state only moves on commit or an idle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_next  <= '0;
      h_state <= '0;
    end else begin
      if (res_valid_c) h_next[res_idx_c] <= res_c;
      if (state == COMMIT) h_state <= h_next;
      else if (state == IDLE && h_clear) h_state <= '0;
    end
  end

endmodule

// File: tb/tb_gru_hidden_state_update.sv
// Directed-vector bench for gru_hidden_state_update with H=4, Q8.8 words.
module tb_gru_hidden_state_update;

  localparam int unsigned H  = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned FB = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               h_clear;
  logic               in_valid;
  logic               in_ready;
  logic [DW-1:0]      z_in;
  logic [DW-1:0]      n_in;
  logic [H-1:0][DW-1:0] h_state;
  logic               busy;
  logic               done;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_h;

  always #5 clk = ~clk;

  gru_hidden_state_update #(
    .H(H), .DATA_WIDTH(DW), .FRAC_BITS(FB)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .h_clear (h_clear),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .z_in    (z_in),
    .n_in    (n_in),
    .h_state (h_state),
    .busy    (busy),
    .done    (done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rep(input logic [15:0] v);
    return {v, v, v, v};
  endfunction

  // One back-to-back timestep; start is sampled at edge 0, done expected at edge 6.
  task automatic run_step(input string tag, input logic [63:0] z, input logic [63:0] n,
                          input logic [63:0] nexp, input logic clr);
    start = 1'b1; h_clear = clr;
    tick;
    start = 1'b0; h_clear = 1'b0;
    if (clr) exp_h = '0;
    check({tag, " busy"}, 64'(busy), 64'd1);
    check({tag, " ready"}, 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; z_in = z[i*16 +: 16]; n_in = n[i*16 +: 16];
      tick;
    end
    in_valid = 1'b0;
    check({tag, " ready_drain"}, 64'(in_ready), 64'd0);
    check({tag, " h_hold"}, h_state, exp_h);
    tick;
    check({tag, " done_early"}, 64'(done), 64'd0);
    tick;
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " busy_end"}, 64'(busy), 64'd0);
    check({tag, " h_new"}, h_state, nexp);
    tick;
    check({tag, " done_clr"}, 64'(done), 64'd0);
    exp_h = nexp;
  endtask

  initial begin
    logic [6:0]  pat;
    logic [63:0] nv;
    int k;
    rst_n = 1'b0; start = 1'b0; h_clear = 1'b0; in_valid = 1'b0;
    z_in = '0; n_in = '0; exp_h = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst h_state", h_state, 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst ready", 64'(in_ready), 64'd0);
    check("rst done", 64'(done), 64'd0);
    rst_n = 1'b1;
    tick;

    h_clear = 1'b1; tick; h_clear = 1'b0;
    check("clear", h_state, 64'd0);

    run_step("ident", 64'd0, 64'h8000_7FFF_FF00_0100, 64'h8000_7FFF_FF00_0100, 1'b0);
    run_step("load200", 64'd0, rep(16'h0200), rep(16'h0200), 1'b0);
    run_step("half", rep(16'h0080), 64'd0, rep(16'h0100), 1'b0);
    run_step("clamp_one", rep(16'h0180), 64'd0, rep(16'h0100), 1'b0);
    run_step("clamp_neg", rep(16'hFF00), rep(16'h0055), rep(16'h0055), 1'b0);
    run_step("floor_pos", rep(16'h0080), 64'd0, rep(16'h002A), 1'b0);
    run_step("load_neg", 64'd0, rep(16'hFFAB), rep(16'hFFAB), 1'b0);
    run_step("floor_neg", rep(16'h0080), 64'd0, rep(16'hFFD5), 1'b0);
    run_step("start_clr", rep(16'h0100), rep(16'h0123), 64'd0, 1'b1);
    run_step("mixed", 64'h0000_0100_00C0_0040, 64'h1234_0010_FF00_0400,
             64'h1234_0000_FFC0_0300, 1'b0);

    // in_valid in IDLE must be ignored.
    in_valid = 1'b1; z_in = 16'h0100; n_in = 16'h7777;
    for (int c = 0; c < 2; c++) begin
      tick;
      check("idle ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    start = 1'b1; tick; start = 1'b0;

    // Bubbles, plus start and h_clear pulses while busy.
    pat = 7'b1011001;
    nv  = 64'h0044_0033_0022_0011;
    k   = 0;
    for (int c = 0; c < 7; c++) begin
      if (pat[c]) begin
        in_valid = 1'b1; z_in = 16'h0000; n_in = nv[k*16 +: 16]; k++;
      end else begin
        in_valid = 1'b0; z_in = 16'h0100; n_in = 16'h7777;
      end
      start   = (c == 1);
      h_clear = (c == 2);
      tick;
      start = 1'b0; h_clear = 1'b0;
      check("bub ready", 64'(in_ready), (c < 6) ? 64'd1 : 64'd0);
      check("bub h_hold", h_state, exp_h);
    end
    in_valid = 1'b0;
    tick;
    check("bub done_early", 64'(done), 64'd0);
    tick;
    check("bub done", 64'(done), 64'd1);
    check("bub h_new", h_state, nv);
    tick;
    check("bub done_clr", 64'(done), 64'd0);
    exp_h = nv;

    // Asynchronous reset in the middle of a timestep.
    start = 1'b1; tick; start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; z_in = 16'h0000; n_in = 16'h5555;
      tick;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mrst h_state", h_state, 64'd0);
    check("mrst busy", 64'(busy), 64'd0);
    check("mrst ready", 64'(in_ready), 64'd0);
    check("mrst done", 64'(done), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_h = '0;
    tick;
    run_step("post_rst", 64'd0, 64'h0004_0003_0002_0001, 64'h0004_0003_0002_0001, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
